// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the dmem_responder slice:
//               responder FSM states, access-size encoding, the width of the
//               wait-state down-counter, and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Down-counter width; holds WAIT_STATES values 0..15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Byte qualifier wins over half-word qualifier; neither means a word.
    function automatic size_t decode_size(input logic is_byte, input logic is_half);
        size_t sz;
        if (is_byte)      sz = SZ_BYTE;
        else if (is_half) sz = SZ_HALF;
        else              sz = SZ_WORD;
        return sz;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] align_mask(input size_t sz);
        logic [1:0] m;
        case (sz)
            SZ_HALF: m = 2'b01;
            SZ_WORD: m = 2'b11;
            default: m = 2'b00;
        endcase
        return m;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_format.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_format
// Description : Combinational byte-lane formatter. Lane k always maps to the
//               byte at effective address a+k (big-endian: lane 0 is the most
//               significant byte of the access).
//   size     in  : access size (byte / half / word)
//   sign_ext in  : loads sign-extend when 1, zero-extend when 0
//   rd_bytes in  : memory bytes at a+0..a+3
//   wr_data  in  : right-justified store data
//   ld_data  out : extended load result
//   wr_bytes out : store bytes per lane
//   wr_be    out : lane write enables
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_format
    import dmem_pkg::*;
(
    input  size_t             size,
    input  logic              sign_ext,
    input  logic [3:0][7:0]   rd_bytes,
    input  logic [31:0]       wr_data,
    output logic [31:0]       ld_data,
    output logic [3:0][7:0]   wr_bytes,
    output logic [3:0]        wr_be
);

    logic w_fill;

    // Extension fill bit comes from the MSB of lane 0 for every size.
    assign w_fill = sign_ext & rd_bytes[0][7];

    always_comb begin
        ld_data  = '0;
        wr_bytes = '0;
        wr_be    = 4'b0000;
        case (size)
            SZ_BYTE: begin
                ld_data     = {{24{w_fill}}, rd_bytes[0]};
                wr_bytes[0] = wr_data[7:0];
                wr_be       = 4'b0001;
            end
            SZ_HALF: begin
                ld_data     = {{16{w_fill}}, rd_bytes[0], rd_bytes[1]};
                wr_bytes[0] = wr_data[15:8];
                wr_bytes[1] = wr_data[7:0];
                wr_be       = 4'b0011;
            end
            SZ_WORD: begin
                ld_data     = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
                wr_bytes[0] = wr_data[31:24];
                wr_bytes[1] = wr_data[23:16];
                wr_bytes[2] = wr_data[15:8];
                wr_bytes[3] = wr_data[7:0];
                wr_be       = 4'b1111;
            end
            default: begin
                ld_data  = '0;
                wr_bytes = '0;
                wr_be    = 4'b0000;
            end
        endcase
    end

endmodule : dmem_lane_format
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-port big-endian data memory with a request/ack
//               handshake and a programmable number of wait states.
//   clock, reset (async, active-low)
//   req_valid, addr, write_enable, mem_byte, mem_half_word, sign_extend,
//   data_in                        : request side (latched on acceptance)
//   ack, data_out, busy, err       : registered response side
// Build option: define DMEM_ALIGN_CHECK_EN to fault misaligned half/word
//               accesses instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int SIZE        = 16384,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic        mem_byte,
    input  logic        mem_half_word,
    input  logic        sign_extend,
    input  logic [31:0] data_in,
    output logic        ack,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(SIZE);
    localparam logic [WAIT_CNT_W-1:0] C_WAIT_LOAD =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  we_q, we_d;
    size_t                 size_q, size_d;
    logic                  sext_q, sext_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  misal_q, misal_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [31:0]           dout_q, dout_d;
    logic                  live_q;

    logic [7:0]            mem [SIZE];

    size_t                 w_size_in;
    logic [AW-1:0]         w_addr_in;
    logic                  w_misal_in;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_do_write;
    logic [3:0][AW-1:0]    w_idx;
    logic [3:0][7:0]       w_rd_bytes;
    logic [3:0][7:0]       w_wr_bytes;
    logic [3:0]            w_wr_be;
    logic [31:0]           w_ld_data;
    logic                  unused_addr_hi;

    // Bits above the array size only select an alias of the same storage.
    assign unused_addr_hi = ^addr[31:AW];
    assign w_size_in      = decode_size(mem_byte, mem_half_word);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_addr_in  = addr[AW-1:0];
    assign w_misal_in = |(addr[1:0] & align_mask(w_size_in));
`else
    assign w_addr_in  = addr[AW-1:0] & ~{{(AW-2){1'b0}}, align_mask(w_size_in)};
    assign w_misal_in = 1'b0;
`endif

    // live_q holds off acceptance (and thus any store) until the first edge
    // after reset release, so nothing can be committed while reset is low.
    assign w_accept = (state_q == ST_IDLE) && req_valid && live_q;

    // Request fields: the _d value is the transaction currently in service,
    // either being accepted this cycle or already latched.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        misal_d = misal_q;
        if (w_accept) begin
            addr_d  = w_addr_in;
            we_d    = write_enable;
            size_d  = w_size_in;
            sext_d  = sign_extend;
            wdata_d = data_in;
            misal_d = w_misal_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RESP always exits to IDLE, so a next state of RESP is an entry edge.
    assign w_enter_resp = (state_d == ST_RESP);
    assign w_do_write   = w_enter_resp && we_d && !misal_d;

    always_comb begin
        ack_d  = w_enter_resp;
        busy_d = (state_d != ST_IDLE);
        err_d  = w_enter_resp && misal_d;
        dout_d = (w_enter_resp && !we_d && !misal_d) ? w_ld_data : 32'd0;
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            // AW-bit addition wraps past the top of the array.
            assign w_idx[k]      = addr_d + AW'(k);
            assign w_rd_bytes[k] = mem[w_idx[k]];
        end
    endgenerate

    dmem_lane_format u_fmt (
        .size     (size_d),
        .sign_ext (sext_d),
        .rd_bytes (w_rd_bytes),
        .wr_data  (wdata_d),
        .ld_data  (w_ld_data),
        .wr_bytes (w_wr_bytes),
        .wr_be    (w_wr_be)
    );

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_be[k]) mem[w_idx[k]] <= w_wr_bytes[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            misal_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            misal_q <= misal_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign data_out = dout_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Instance
//               u_dut uses WAIT_STATES=2, u_dut0 uses WAIT_STATES=0.
//               Expectations for misaligned accesses follow the
//               DMEM_ALIGN_CHECK_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int C_TIMEOUT = 20;

    logic        clock;
    logic        reset;

    logic        req_valid, write_enable, mem_byte, mem_half_word, sign_extend;
    logic [31:0] addr, data_in;
    logic        ack, busy, err;
    logic [31:0] data_out;

    logic        req0, we0, byte0, half0, sext0;
    logic [31:0] addr0, din0;
    logic        ack0, busy0, err0;
    logic [31:0] dout0;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.SIZE(16384), .WAIT_STATES(2)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .addr          (addr),
        .write_enable  (write_enable),
        .mem_byte      (mem_byte),
        .mem_half_word (mem_half_word),
        .sign_extend   (sign_extend),
        .data_in       (data_in),
        .ack           (ack),
        .data_out      (data_out),
        .busy          (busy),
        .err           (err)
    );

    dmem_responder #(.SIZE(16384), .WAIT_STATES(0)) u_dut0 (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req0),
        .addr          (addr0),
        .write_enable  (we0),
        .mem_byte      (byte0),
        .mem_half_word (half0),
        .sign_extend   (sext0),
        .data_in       (din0),
        .ack           (ack0),
        .data_out      (dout0),
        .busy          (busy0),
        .err           (err0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on u_dut. Inputs are scrambled after acceptance so
    // that any late sampling of the request fields shows up as bad data.
    task automatic run_txn(input logic we, input logic b, input logic h,
                           input logic sx, input logic [31:0] a,
                           input logic [31:0] d, output int n,
                           output logic [31:0] dout, output logic e,
                           output logic bsy);
        @(negedge clock);
        req_valid = 1'b1; write_enable = we; mem_byte = b; mem_half_word = h;
        sign_extend = sx; addr = a; data_in = d;
        bsy = 1'b1; dout = 32'd0; e = 1'b0;
        for (n = 1; n <= C_TIMEOUT; n++) begin
            @(posedge clock); #1;
            if (!busy) bsy = 1'b0;
            if (ack) break;
            addr = ~a; data_in = ~d; write_enable = ~we; sign_extend = ~sx;
            mem_byte = ~b; mem_half_word = ~h;
        end
        dout = data_out;
        e    = err;
        req_valid = 1'b0;
        checks++;
        if (n > C_TIMEOUT) begin
            failures++;
            $display("FAIL txn_timeout: no ack within %0d cycles (addr=%h)", C_TIMEOUT, a);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 0; write_enable = 0; mem_byte = 0; mem_half_word = 0;
        sign_extend = 0; addr = 0; data_in = 0;
        req0 = 0; we0 = 0; byte0 = 0; half0 = 0; sext0 = 0; addr0 = 0; din0 = 0;
        #2;
        checks++; if (ack !== 1'b0)       begin failures++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0)       begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (ack0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL reset_dut0: got ack=%b busy=%b want 0 0", ack0, busy0); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_word();
        int n; logic [31:0] d; logic e, b;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h1234_5678, n, d, e, b);
        checks++; if (n !== 3)    begin failures++; $display("FAIL word_store_latency: got %0d want 3", n); end
        checks++; if (b !== 1'b1) begin failures++; $display("FAIL word_store_busy: got %b want 1", b); end
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0, n, d, e, b);
        checks++; if (n !== 3)             begin failures++; $display("FAIL word_load_latency: got %0d want 3", n); end
        checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL word_load_data: got %h want 12345678", d); end
        checks++; if (e !== 1'b0)          begin failures++; $display("FAIL word_load_err: got %b want 0", e); end
        checks++; if (ack !== 1'b0 || busy !== 1'b0 || data_out !== 32'd0) begin
            failures++; $display("FAIL after_ack_idle: got ack=%b busy=%b data=%h want 0 0 0", ack, busy, data_out);
        end
    endtask

    task automatic test_byte_sign();
        int n; logic [31:0] d; logic e, b;
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'hFFFF_FF80, n, d, e, b);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2001, 32'h0, n, d, e, b);
        checks++; if (d !== 32'hFFFF_FF80) begin failures++; $display("FAIL byte_load_sext: got %h want ffffff80", d); end
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h0000_0080) begin failures++; $display("FAIL byte_load_zext: got %h want 00000080", d); end
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h1280_5678) begin failures++; $display("FAIL byte_store_neighbours: got %h want 12805678", d); end
    endtask

    task automatic test_half();
        int n; logic [31:0] d; logic e, b;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2004, 32'hA5A5_A5A5, n, d, e, b);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2002, 32'h1234_BEEF, n, d, e, b);
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2002, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h0000_00BE) begin failures++; $display("FAIL half_store_byte2002: got %h want 000000be", d); end
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2003, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h0000_00EF) begin failures++; $display("FAIL half_store_byte2003: got %h want 000000ef", d); end
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h1280_BEEF) begin failures++; $display("FAIL half_store_low_neighbours: got %h want 1280beef", d); end
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2004, 32'h0, n, d, e, b);
        checks++; if (d !== 32'hA5A5_A5A5) begin failures++; $display("FAIL half_store_high_neighbours: got %h want a5a5a5a5", d); end
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2002, 32'h0, n, d, e, b);
        checks++; if (d !== 32'hFFFF_BEEF) begin failures++; $display("FAIL half_load_sext: got %h want ffffbeef", d); end
    endtask

    task automatic test_align_wrap();
        int n; logic [31:0] d; logic e, b;
        logic [31:0] exp_w, exp_h; logic exp_e;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_w = 32'h0; exp_h = 32'h0; exp_e = 1'b1;
`else
        exp_w = 32'h0A0B_0C0D; exp_h = 32'h0000_BEEF; exp_e = 1'b0;
`endif
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3FFC, 32'h0A0B_0C0D, n, d, e, b);
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3FFE, 32'h0, n, d, e, b);
        checks++; if (d !== exp_w) begin failures++; $display("FAIL word_3ffe_data: got %h want %h", d, exp_w); end
        checks++; if (e !== exp_e) begin failures++; $display("FAIL word_3ffe_err: got %b want %b", e, exp_e); end
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2003, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h0000_00EF) begin failures++; $display("FAIL byte_over_half: got %h want 000000ef", d); end
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2003, 32'h0, n, d, e, b);
        checks++; if (d !== exp_h || e !== exp_e) begin failures++; $display("FAIL half_odd: got data=%h err=%b want %h %b", d, e, exp_h, exp_e); end
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0001_2000, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h1280_BEEF) begin failures++; $display("FAIL addr_modulo: got %h want 1280beef", d); end
    endtask

    task automatic test_reset_abort();
        int n; logic [31:0] d; logic e, b;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h1122_3344, n, d, e, b);
        @(negedge clock);
        req_valid = 1'b1; write_enable = 1'b1; mem_byte = 1'b0; mem_half_word = 1'b0;
        addr = 32'h0000_0100; data_in = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_async_clear: got ack=%b busy=%b want 0 0", ack, busy); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, n, d, e, b);
        checks++; if (d !== 32'h1122_3344) begin failures++; $display("FAIL abort_mem_unchanged: got %h want 11223344", d); end
    endtask

    task automatic test_back_to_back();
        logic exp;
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; byte0 = 1'b0; half0 = 1'b0; sext0 = 1'b0;
        addr0 = 32'h0000_0040; din0 = 32'hCAFE_F00D;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            exp = ((k % 2) == 0);
            checks++;
            if (ack0 !== exp || busy0 !== exp) begin
                failures++; $display("FAIL b2b_cycle%0d: got ack=%b busy=%b want %b %b", k, ack0, busy0, exp, exp);
            end
        end
        req0 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0;
        @(posedge clock); #1;
        req0 = 1'b0;
        checks++; if (ack0 !== 1'b1 || dout0 !== 32'hCAFE_F00D || err0 !== 1'b0) begin
            failures++; $display("FAIL w0_load: got ack=%b data=%h err=%b want 1 cafef00d 0", ack0, dout0, err0);
        end
        @(posedge clock); #1;
        checks++; if (ack0 !== 1'b0 || dout0 !== 32'd0) begin
            failures++; $display("FAIL w0_after_ack: got ack=%b data=%h want 0 0", ack0, dout0);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_sign();
        test_half();
        test_align_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
